// File: rtl/fir_pkg.sv
// Shared defaults and sequencer state encoding for the FIR stream controller.
package fir_pkg;

  localparam int unsigned N1Default = 8;
  localparam int unsigned N2Default = 16;
  localparam int unsigned N3Default = 32;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Sample input stream and result output stream of the FIR stream controller.
interface fir_stream_ctrl_if
  import fir_pkg::*;
#(
  parameter int unsigned N2 = N2Default,
  parameter int unsigned N3 = N3Default
);
  logic          s_valid;
  logic          s_ready;
  logic [N2-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [N3-1:0] m_data;
  logic          m_warm;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_warm
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_warm
  );
endinterface

// File: rtl/fir_out_fifo.sv
// Two-entry result FIFO; push and pop may coincide at any occupancy.
module fir_out_fifo #(
  parameter int unsigned Width = 33
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);
  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  assign empty    = (count_q == 2'd0);
  assign full     = (count_q == 2'd2);
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clr) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/fir_stream_ctrl.sv
// Stream front-end and sequencer for the 8-tap FIR: strobes samples into the filter, captures
// results into a 2-deep FIFO and sequences flush / filter clear between sample blocks.
module fir_stream_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned N1 = N1Default,
  parameter int unsigned N2 = N2Default,
  parameter int unsigned N3 = N3Default
) (
  input  logic             CLK,
  input  logic             RST,
  fir_stream_ctrl_if.slave bus,
  input  logic             clear_req,
  output logic             fir_enable,
  output logic             fir_rst,
  output logic [N2-1:0]    fir_data,
  input  logic [N3-1:0]    fir_result,
  output logic             busy
);
  localparam int unsigned      ZcW      = $clog2(N1);
  localparam int unsigned      FillW    = $clog2(N1 + 1);
  localparam logic [ZcW-1:0]   ZcLast   = ZcW'(N1 - 2);
  localparam logic [FillW-1:0] FillFull = FillW'(N1);

  state_e           state_q;
  logic             fir_rst_q;
  logic             inflight_q;
  logic             warm_q;
  logic [ZcW-1:0]   zcnt_q;
  logic [FillW-1:0] fill_q;
  logic [FillW-1:0] fill_next;

  logic [1:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic [N3:0] fifo_rdata;
  logic [2:0]  occ;
  logic        space_ok;
  logic        s_ready;
  logic        pop;

  // A result still in the filter pipeline reserves a FIFO slot just like a stored one.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign space_ok  = (occ < 3'd2);
  assign fill_next = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
  assign pop       = !fifo_empty && bus.m_ready;

  assign bus.s_ready = s_ready;
  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = fifo_rdata[N3-1:0];
  assign bus.m_warm  = fifo_rdata[N3];
  assign fir_rst     = fir_rst_q;
  assign busy        = (state_q != StRun) || !fifo_empty || inflight_q;

  always_comb begin
    s_ready    = 1'b0;
    fir_enable = 1'b0;
    fir_data   = '0;
    unique case (state_q)
      StRun: begin
        s_ready    = space_ok && !clear_req;
        fir_enable = bus.s_valid && s_ready;
        fir_data   = bus.s_data;
      end
      StFlush: fir_enable = space_ok && !clear_req;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StClear;
      fir_rst_q  <= 1'b0;
      inflight_q <= 1'b0;
      warm_q     <= 1'b0;
      zcnt_q     <= '0;
      fill_q     <= '0;
    end else begin
      inflight_q <= fir_enable;
      warm_q     <= (fill_next == FillFull);
      fir_rst_q  <= 1'b0;
      if (fir_enable) begin
        fill_q <= fill_next;
      end
      if (clear_req) begin
        state_q   <= StClear;
        fir_rst_q <= 1'b1;
        zcnt_q    <= '0;
        fill_q    <= '0;
      end else begin
        unique case (state_q)
          // Coming out of reset the filter pulse has not happened yet, so issue it first.
          StClear: begin
            fill_q <= '0;
            if (fir_rst_q) state_q <= StRun;
            else           fir_rst_q <= 1'b1;
          end
          StRun: begin
            if (fir_enable && bus.s_last) begin
              state_q <= StFlush;
              zcnt_q  <= '0;
            end
          end
          StFlush: begin
            if (fir_enable) begin
              if (zcnt_q == ZcLast) state_q <= StDrain;
              else                  zcnt_q  <= zcnt_q + 1'b1;
            end
          end
          StDrain: begin
            if (fifo_empty && !inflight_q) begin
              state_q   <= StClear;
              fir_rst_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  fir_out_fifo #(
    .Width (N3 + 1)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (clear_req),
    .push      (inflight_q),
    .push_data ({warm_q, fir_result}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assert property (@(posedge CLK) disable iff (!RST) !(inflight_q && fifo_full && !pop));
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl paired with a behavioural 8-tap filter (all coefficients 0x10).
module tb_fir_stream_ctrl;
  import fir_pkg::*;

  localparam int unsigned N1 = N1Default;
  localparam int unsigned N2 = N2Default;
  localparam int unsigned N3 = N3Default;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 clear_req;
  logic                 fir_enable;
  logic                 fir_rst;
  logic signed [N2-1:0] fir_data;
  logic        [N3-1:0] fir_result;
  logic                 busy;

  fir_stream_ctrl_if #(.N2(N2), .N3(N3)) bus ();

  fir_stream_ctrl #(.N1(N1), .N2(N2), .N3(N3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .clear_req  (clear_req),
    .fir_enable (fir_enable),
    .fir_rst    (fir_rst),
    .fir_data   (fir_data),
    .fir_result (fir_result),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Neighbouring filter: registered output, sync reset, coefficients all 16.
  logic signed [N2-1:0] taps [N1];

  function automatic int window_sum(input logic signed [N2-1:0] d);
    int acc = int'(d);
    for (int i = 0; i < int'(N1) - 1; i++) acc += int'(taps[i]);
    return acc;
  endfunction

  always @(posedge CLK) begin
    if (fir_rst) begin
      for (int i = 0; i < int'(N1); i++) taps[i] <= '0;
      fir_result <= '0;
    end else if (fir_enable) begin
      for (int i = int'(N1) - 1; i > 0; i--) taps[i] <= taps[i-1];
      taps[0]    <= fir_data;
      fir_result <= N3'(16 * window_sum(fir_data));
    end
  end

  // Reference model: phase, filter history since last clear, results owed to the consumer.
  typedef enum {PhClear, PhRun, PhFlush, PhDrain} ph_e;
  typedef struct {
    int data;
    bit warm;
    int cyc;
  } res_t;

  res_t exp_q[$];
  int   hist[$];
  int   nfed;
  ph_e  ph;
  bit   fresh;
  int   zc;
  int   cyc;
  int   checks;
  int   errors;
  int   cap_data[$];
  bit   cap_warm[$];
  int   acc_cnt;
  bit   last_acc;
  bit   last_busy;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    nfed  = 0;
    ph    = PhClear;
    fresh = 1'b1;
    zc    = 0;
  endtask

  task automatic model_step();
    bit   exp_rdy, exp_en, exp_mv;
    int   qsz, sd, s;
    res_t r;
    cyc++;
    if (!RST) begin
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_fir_enable", fir_enable, 0);
      check("rst_fir_rst", fir_rst, 0);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_busy", busy, 1);
      model_reset();
      return;
    end
    qsz     = exp_q.size();
    sd      = int'($signed(bus.s_data));
    exp_rdy = (ph == PhRun) && !clear_req && (qsz < 2);
    exp_en  = (ph == PhRun && bus.s_valid && exp_rdy) ||
              (ph == PhFlush && !clear_req && qsz < 2);
    exp_mv  = (qsz > 0) && (cyc - exp_q[0].cyc >= 2);
    check("s_ready", bus.s_ready, exp_rdy);
    check("fir_enable", fir_enable, exp_en);
    check("fir_rst", fir_rst, (ph == PhClear) && !fresh);
    check("busy", busy, (ph != PhRun) || (qsz > 0));
    check("m_valid", bus.m_valid, exp_mv);
    if (exp_en) check("fir_data", longint'(fir_data), (ph == PhRun) ? sd : 0);
    if (exp_mv) begin
      check("m_data", longint'($signed(bus.m_data)), exp_q[0].data);
      check("m_warm", bus.m_warm, exp_q[0].warm);
      if (bus.m_ready) begin
        cap_data.push_back(int'($signed(bus.m_data)));
        cap_warm.push_back(bus.m_warm);
        void'(exp_q.pop_front());
      end
    end
    if (exp_en) begin
      hist.push_back((ph == PhRun) ? sd : 0);
      if (hist.size() > int'(N1)) void'(hist.pop_front());
      nfed++;
      s = 0;
      foreach (hist[i]) s += hist[i];
      r.data = 16 * s;
      r.warm = (nfed >= int'(N1));
      r.cyc  = cyc;
      exp_q.push_back(r);
    end
    if (clear_req) begin
      exp_q.delete();
      hist.delete();
      nfed  = 0;
      ph    = PhClear;
      fresh = 1'b0;
    end else begin
      case (ph)
        PhClear: if (fresh) fresh = 1'b0; else ph = PhRun;
        PhRun:   if (exp_en && bus.s_last) begin ph = PhFlush; zc = 0; end
        PhFlush: if (exp_en) begin
          if (zc == int'(N1) - 2) ph = PhDrain;
          else zc++;
        end
        PhDrain: if (qsz == 0) begin ph = PhClear; hist.delete(); nfed = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    last_acc  = bus.s_valid && bus.s_ready;
    last_busy = busy;
    if (last_acc) acc_cnt++;
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int d, input bit last, input string name);
    bit done = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = N2'(d);
    bus.s_last  = last;
    for (int i = 0; i < 30 && !done; i++) begin
      cycle();
      done = last_acc;
    end
    check(name, done, 1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    bit idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      cycle();
      idle = !last_busy;
    end
    check(name, last_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; acc_cnt = 0;
    model_reset();
    RST = 1'b1; clear_req = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    #2 RST = 1'b0;
    repeat (3) cycle();
    RST = 1'b1;

    // 1: constant ones, free-running consumer
    bus.s_valid = 1'b1; bus.s_data = N2'(1); bus.m_ready = 1'b1;
    repeat (30) cycle();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_data%0d", k), (k < cap_data.size()) ? cap_data[k] : -1, 16 * (k + 1));
      check($sformatf("t1_warm%0d", k), (k < cap_warm.size()) ? cap_warm[k] : 2, k >= 7);
    end
    check("t1_steady", (cap_data.size() > 10) ? cap_data[10] : -1, 128);

    // 2: block 2,2,2 with flush
    bus.s_valid = 1'b0;
    clear_req = 1'b1; cycle(); clear_req = 1'b0;
    cycle(); cycle();
    cap_data.delete(); cap_warm.delete();
    send(2, 1'b0, "t2_s0"); send(2, 1'b0, "t2_s1"); send(2, 1'b1, "t2_s2");
    wait_idle(100, "t2_idle");
    check("t2_count", cap_data.size(), 10);
    check("t2_r0", (cap_data.size() > 0) ? cap_data[0] : -1, 32);
    check("t2_r1", (cap_data.size() > 1) ? cap_data[1] : -1, 64);
    check("t2_r2", (cap_data.size() > 2) ? cap_data[2] : -1, 96);
    check("t2_r8", (cap_data.size() > 8) ? cap_data[8] : -1, 64);

    // 3: backpressure
    cap_data.delete(); cap_warm.delete(); acc_cnt = 0;
    bus.m_ready = 1'b0; bus.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.s_data = N2'($urandom_range(0, 500));
      cycle();
    end
    check("t3_accepts", acc_cnt, 2);
    check("t3_s_ready", bus.s_ready, 0);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.s_data = N2'($urandom_range(0, 500));
      cycle();
    end
    bus.s_valid = 1'b0;
    repeat (10) cycle();
    check("t3_delivered", cap_data.size(), acc_cnt);

    // 4: clear during a stalled flush
    bus.m_ready = 1'b0;
    send(7, 1'b1, "t4_last");
    repeat (6) cycle();
    check("t4_full_valid", bus.m_valid, 1);
    clear_req = 1'b1; cycle(); clear_req = 1'b0;
    check("t4_m_valid", bus.m_valid, 0);
    check("t4_fir_rst", fir_rst, 1);
    bus.m_ready = 1'b1;
    cycle();
    cap_data.delete(); cap_warm.delete();
    send(5, 1'b0, "t4_s5");
    repeat (4) cycle();
    check("t4_result", (cap_data.size() > 0) ? cap_data[0] : -1, 80);
    check("t4_warm", (cap_warm.size() > 0) ? cap_warm[0] : 2, 0);

    // 5: asynchronous reset with a result in flight
    bus.s_valid = 1'b1; bus.s_data = N2'(3);
    cycle();
    #2 RST = 1'b0;
    #1;
    check("t5_s_ready", bus.s_ready, 0);
    check("t5_fir_enable", fir_enable, 0);
    check("t5_fir_rst", fir_rst, 0);
    check("t5_fir_data", fir_data, 0);
    check("t5_m_valid", bus.m_valid, 0);
    check("t5_m_data", bus.m_data, 0);
    check("t5_m_warm", bus.m_warm, 0);
    check("t5_busy", busy, 1);
    repeat (2) cycle();
    RST = 1'b1; bus.s_valid = 1'b0;
    repeat (8) cycle();

    // 6: clear_req beats s_last
    wait_idle(20, "t6_ready");
    bus.s_valid = 1'b1; bus.s_last = 1'b1; bus.s_data = N2'(9); clear_req = 1'b1;
    cycle();
    check("t6_not_accepted", last_acc, 0);
    clear_req = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    repeat (3) cycle();
    check("t6_no_flush", last_busy, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.s_valid = ($urandom_range(0, 9) < 7);
      bus.s_data  = N2'(int'($urandom_range(0, 2000)) - 1000);
      bus.s_last  = ($urandom_range(0, 15) == 0);
      bus.m_ready = ($urandom_range(0, 9) < 6);
      clear_req   = ($urandom_range(0, 99) == 0);
      cycle();
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b1; clear_req = 1'b0;
    wait_idle(300, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
